// File: rtl/afifo_wr_burst_engine_pkg.sv
// Shared types for the async FIFO write-side burst engine.
package afifo_pkg;

  typedef enum logic [1:0] {
    PAT_INCR  = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_CONST = 2'd2,
    PAT_WALK1 = 2'd3
  } afifo_wr_pat_e;

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_BURST = 2'd1,
    ENG_GAP   = 2'd2
  } afifo_wr_eng_state_e;

  localparam int STALL_CNT_WIDTH = 32;

endpackage

// File: rtl/afifo_wr_burst_engine_if.sv
// Command, FIFO write port and status bundle of the write burst engine.
// master = test/config side plus FIFO model, slave = the engine.
interface afifo_wr_burst_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 4
);
  import afifo_pkg::*;

  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic [LEN_WIDTH-1:0]                  cmd_len;
  afifo_wr_pat_e                         cmd_pattern;
  logic [DATA_WIDTH-1:0]                 cmd_seed;
  logic [GAP_WIDTH-1:0]                  cmd_gap;
  logic                                  cmd_drop_on_full;
  logic                                  abort;
  logic                                  wfull;
  logic                                  winc;
  logic [DATA_WIDTH-1:0]                 wdata;
  logic                                  busy;
  logic                                  done;
  logic                                  err_timeout;
  logic [LEN_WIDTH-1:0]                  wr_count;
  logic [LEN_WIDTH-1:0]                  drop_count;
  logic [STALL_CNT_WIDTH-1:0]            stall_cycles;

  modport master (
    output cmd_valid, cmd_len, cmd_pattern, cmd_seed, cmd_gap, cmd_drop_on_full, abort, wfull,
    input  cmd_ready, winc, wdata, busy, done, err_timeout, wr_count, drop_count, stall_cycles
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_pattern, cmd_seed, cmd_gap, cmd_drop_on_full, abort, wfull,
    output cmd_ready, winc, wdata, busy, done, err_timeout, wr_count, drop_count, stall_cycles
  );

endinterface

// File: rtl/afifo_wr_burst_engine_pattern_gen.sv
// Registered data pattern source: load picks the first word, advance steps to the next.
module afifo_pattern_gen
  import afifo_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] LFSR_POLY  = 32'h8020_0003
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] seed,
  input  afifo_wr_pat_e         pattern,
  output logic [DATA_WIDTH-1:0] data
);

  localparam logic [DATA_WIDTH-1:0] POLY = DATA_WIDTH'(LFSR_POLY);

  afifo_wr_pat_e         pat_q;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] next_val;

  // First word: WALK1 always starts at bit 0; an all-zero LFSR seed would lock up, so force 1.
  always_comb begin
    load_val = seed;
    case (pattern)
      PAT_WALK1: load_val = DATA_WIDTH'(1);
      PAT_LFSR:  load_val = (seed == '0) ? DATA_WIDTH'(1) : seed;
      default:   load_val = seed;
    endcase
  end

  // Successor of the current word; the LFSR is a right-shifting Galois form.
  always_comb begin
    next_val = data;
    case (pat_q)
      PAT_INCR:  next_val = data + DATA_WIDTH'(1);
      PAT_LFSR:  next_val = (data >> 1) ^ (data[0] ? POLY : '0);
      PAT_CONST: next_val = data;
      PAT_WALK1: next_val = {data[DATA_WIDTH-2:0], data[DATA_WIDTH-1]};
      default:   next_val = data;
    endcase
  end

  // Data and active pattern registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      pat_q <= PAT_INCR;
    end else if (load) begin
      data  <= load_val;
      pat_q <= pattern;
    end else if (advance) begin
      data  <= next_val;
    end
  end

endmodule

// File: rtl/afifo_wr_burst_engine.sv
// Write-domain burst engine: takes burst commands and drives the FIFO write port.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ENG_IDLE  | ready for a command; counters hold last burst's results
//   ENG_BURST | one word per cycle: write, drop or stall depending on wfull
//   ENG_GAP   | idle cycles between words, wfull ignored
module afifo_wr_burst_engine
  import afifo_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          LEN_WIDTH  = 16,
  parameter int          GAP_WIDTH  = 4,
  parameter int          TIMEOUT    = 1024,
  parameter logic [31:0] LFSR_POLY  = 32'h8020_0003
) (
  input  logic                    wclk,
  input  logic                    wrst,
  afifo_wr_burst_engine_if.slave  bus
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 1 || ADDR_WIDTH < 1) begin : g_bad_param
    $error("afifo_wr_burst_engine: TIMEOUT and ADDR_WIDTH must be at least 1");
  end

  afifo_wr_eng_state_e        state, state_nxt;
  logic [LEN_WIDTH-1:0]       remaining;
  logic [GAP_WIDTH-1:0]       gap_q, gap_ctr;
  logic                       drop_q;
  logic [TO_W-1:0]            to_ctr;
  logic                       busy_q, done_q, err_q;
  logic [LEN_WIDTH-1:0]       wr_cnt_q, drop_cnt_q;
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  logic accept, in_burst, write_ev, drop_ev, stall_ev, consume, last, timeout_hit, abort_ev;

  assign accept      = bus.cmd_valid && (state == ENG_IDLE);
  assign in_burst    = (state == ENG_BURST) && !bus.abort;
  assign write_ev    = in_burst && !bus.wfull;
  assign drop_ev     = in_burst && bus.wfull && drop_q;
  assign stall_ev    = in_burst && bus.wfull && !drop_q;
  assign consume     = write_ev || drop_ev;
  assign last        = (remaining == LEN_WIDTH'(1));
  assign timeout_hit = stall_ev && (to_ctr == TO_W'(TIMEOUT - 1));
  assign abort_ev    = bus.abort && (state != ENG_IDLE);

  // State register.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) state <= ENG_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ENG_IDLE: begin
        if (accept && (bus.cmd_len != '0)) state_nxt = ENG_BURST;
      end
      ENG_BURST: begin
        if (bus.abort)         state_nxt = ENG_IDLE;
        else if (consume)      state_nxt = last ? ENG_IDLE : ((gap_q != '0) ? ENG_GAP : ENG_BURST);
        else if (timeout_hit)  state_nxt = ENG_IDLE;
      end
      ENG_GAP: begin
        if (bus.abort)                       state_nxt = ENG_IDLE;
        else if (gap_ctr == GAP_WIDTH'(1))   state_nxt = ENG_BURST;
      end
      default: state_nxt = ENG_IDLE;
    endcase
  end

  // Burst bookkeeping: remaining words, gap/timeout timers, status counters and flags.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      remaining  <= '0;
      gap_q      <= '0;
      gap_ctr    <= '0;
      drop_q     <= 1'b0;
      to_ctr     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_cnt_q   <= '0;
      drop_cnt_q <= '0;
      stall_q    <= '0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_nxt != ENG_IDLE);
      if (accept) begin
        remaining  <= bus.cmd_len;
        gap_q      <= bus.cmd_gap;
        drop_q     <= bus.cmd_drop_on_full;
        to_ctr     <= '0;
        err_q      <= 1'b0;
        wr_cnt_q   <= '0;
        drop_cnt_q <= '0;
        stall_q    <= '0;
        done_q     <= (bus.cmd_len == '0);
      end
      if (write_ev) begin
        wr_cnt_q  <= wr_cnt_q + LEN_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
        to_ctr    <= '0;
      end
      if (drop_ev) begin
        drop_cnt_q <= drop_cnt_q + LEN_WIDTH'(1);
        remaining  <= remaining - LEN_WIDTH'(1);
      end
      if (consume && last) done_q <= 1'b1;
      if (stall_ev) begin
        if (stall_q != '1) stall_q <= stall_q + STALL_CNT_WIDTH'(1);
        to_ctr <= to_ctr + TO_W'(1);
        if (timeout_hit) begin
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end
      end
      if (abort_ev) done_q <= 1'b1;
      if (consume && !last && (gap_q != '0)) gap_ctr <= gap_q;
      else if (state == ENG_GAP)             gap_ctr <= gap_ctr - GAP_WIDTH'(1);
    end
  end

  afifo_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .LFSR_POLY  (LFSR_POLY)
  ) u_pattern_gen (
    .clk     (wclk),
    .rst     (wrst),
    .load    (accept),
    .advance (consume),
    .seed    (bus.cmd_seed),
    .pattern (bus.cmd_pattern),
    .data    (bus.wdata)
  );

  assign bus.cmd_ready    = (state == ENG_IDLE);
  assign bus.winc         = write_ev;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_timeout  = err_q;
  assign bus.wr_count     = wr_cnt_q;
  assign bus.drop_count   = drop_cnt_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_afifo_wr_burst_engine.sv
// Directed bench for the write burst engine; expected values are hand-derived.
module tb_afifo_wr_burst_engine;
  import afifo_pkg::*;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int GW = 4;
  localparam int TO = 8;

  logic wclk = 1'b0;
  logic wrst;

  afifo_wr_burst_engine_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_WIDTH(GW)) bus ();

  afifo_wr_burst_engine #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (8),
    .LEN_WIDTH  (LW),
    .GAP_WIDTH  (GW),
    .TIMEOUT    (TO),
    .LFSR_POLY  (32'h8020_0003)
  ) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  logic          log_winc [32];
  logic [DW-1:0] log_wdata[32];
  logic          log_done [32];
  logic          log_bad  [32];

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic send_cmd(input logic [LW-1:0] len, input afifo_wr_pat_e pat,
                          input logic [DW-1:0] seed, input logic [GW-1:0] gap, input logic drop);
    bus.cmd_valid        = 1'b1;
    bus.cmd_len          = len;
    bus.cmd_pattern      = pat;
    bus.cmd_seed         = seed;
    bus.cmd_gap          = gap;
    bus.cmd_drop_on_full = drop;
    cyc();
    bus.cmd_valid        = 1'b0;
  endtask

  // Runs n cycles with wfull taken from full_mask, logging outputs mid-cycle.
  task automatic run(input int n, input logic [31:0] full_mask);
    for (int i = 0; i < n; i++) begin
      bus.wfull = full_mask[i];
      #1;
      log_winc[i]  = bus.winc;
      log_wdata[i] = bus.wdata;
      log_done[i]  = bus.done;
      log_bad[i]   = bus.winc & bus.wfull;
      @(posedge wclk);
      #1;
    end
    bus.wfull = 1'b0;
  endtask

  task automatic test_reset();
    wrst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_pattern = PAT_INCR; bus.cmd_seed = '0;
    bus.cmd_gap = '0; bus.cmd_drop_on_full = 1'b0; bus.abort = 1'b0; bus.wfull = 1'b0;
    #12;
    checks++; if (bus.winc !== 1'b0)        begin errors++; $display("FAIL reset_winc: got %b expected 0", bus.winc); end
    checks++; if (bus.wdata !== '0)         begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.wdata); end
    checks++; if (bus.busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)        begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_timeout); end
    checks++; if (bus.cmd_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (bus.wr_count !== '0 || bus.drop_count !== '0 || bus.stall_cycles !== '0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", bus.wr_count, bus.drop_count, bus.stall_cycles);
    end
    wrst = 1'b0;
    cyc();
  endtask

  task automatic test_incr();
    send_cmd(16'd4, PAT_INCR, 32'h10, 4'd0, 1'b0);
    run(6, 32'h0);
    for (int i = 0; i < 6; i++) begin
      checks++; if (log_winc[i] !== (i < 4)) begin errors++; $display("FAIL incr_winc[%0d]: got %b expected %b", i, log_winc[i], (i < 4)); end
      if (i < 4) begin
        checks++; if (log_wdata[i] !== 32'h10 + i) begin errors++; $display("FAIL incr_wdata[%0d]: got %h expected %h", i, log_wdata[i], 32'h10 + i); end
      end
      checks++; if (log_done[i] !== (i == 4)) begin errors++; $display("FAIL incr_done[%0d]: got %b expected %b", i, log_done[i], (i == 4)); end
    end
    checks++; if (bus.wr_count !== 16'd4) begin errors++; $display("FAIL incr_wr_count: got %0d expected 4", bus.wr_count); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL incr_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_stall();
    logic [7:0]    exp_w;
    logic [DW-1:0] exp_d[6];
    exp_w = 8'b0011_0001;
    exp_d = '{32'h20, 32'h21, 32'h21, 32'h21, 32'h21, 32'h22};
    send_cmd(16'd3, PAT_INCR, 32'h20, 4'd0, 1'b0);
    run(8, 32'b0_1110);
    for (int i = 0; i < 8; i++) begin
      checks++; if (log_winc[i] !== exp_w[i]) begin errors++; $display("FAIL stall_winc[%0d]: got %b expected %b", i, log_winc[i], exp_w[i]); end
      checks++; if (log_bad[i] !== 1'b0)      begin errors++; $display("FAIL stall_winc_while_full[%0d]: got 1 expected 0", i); end
      if (i < 6) begin
        checks++; if (log_wdata[i] !== exp_d[i]) begin errors++; $display("FAIL stall_wdata[%0d]: got %h expected %h", i, log_wdata[i], exp_d[i]); end
      end
      checks++; if (log_done[i] !== (i == 6)) begin errors++; $display("FAIL stall_done[%0d]: got %b expected %b", i, log_done[i], (i == 6)); end
    end
    checks++; if (bus.stall_cycles !== 32'd3) begin errors++; $display("FAIL stall_cycles: got %0d expected 3", bus.stall_cycles); end
    checks++; if (bus.wr_count !== 16'd3)     begin errors++; $display("FAIL stall_wr_count: got %0d expected 3", bus.wr_count); end
    checks++; if (bus.drop_count !== 16'd0)   begin errors++; $display("FAIL stall_drop_count: got %0d expected 0", bus.drop_count); end
  endtask

  task automatic test_drop();
    logic [5:0] exp_w;
    exp_w = 6'b00_1101;
    send_cmd(16'd4, PAT_INCR, 32'h0, 4'd0, 1'b1);
    run(6, 32'b10);
    for (int i = 0; i < 6; i++) begin
      checks++; if (log_winc[i] !== exp_w[i]) begin errors++; $display("FAIL drop_winc[%0d]: got %b expected %b", i, log_winc[i], exp_w[i]); end
      if (exp_w[i]) begin
        checks++; if (log_wdata[i] !== 32'(i)) begin errors++; $display("FAIL drop_wdata[%0d]: got %h expected %h", i, log_wdata[i], 32'(i)); end
      end
      checks++; if (log_done[i] !== (i == 4)) begin errors++; $display("FAIL drop_done[%0d]: got %b expected %b", i, log_done[i], (i == 4)); end
    end
    checks++; if (bus.drop_count !== 16'd1)   begin errors++; $display("FAIL drop_drop_count: got %0d expected 1", bus.drop_count); end
    checks++; if (bus.wr_count !== 16'd3)     begin errors++; $display("FAIL drop_wr_count: got %0d expected 3", bus.wr_count); end
    checks++; if (bus.stall_cycles !== 32'd0) begin errors++; $display("FAIL drop_stall_cycles: got %0d expected 0", bus.stall_cycles); end
  endtask

  task automatic test_timeout();
    send_cmd(16'd5, PAT_INCR, 32'h55, 4'd0, 1'b0);
    run(10, 32'h3FF);
    for (int i = 0; i < 10; i++) begin
      checks++; if (log_winc[i] !== 1'b0)     begin errors++; $display("FAIL to_winc[%0d]: got %b expected 0", i, log_winc[i]); end
      checks++; if (log_done[i] !== (i == 8)) begin errors++; $display("FAIL to_done[%0d]: got %b expected %b", i, log_done[i], (i == 8)); end
    end
    checks++; if (bus.err_timeout !== 1'b1)   begin errors++; $display("FAIL to_err: got %b expected 1", bus.err_timeout); end
    checks++; if (bus.stall_cycles !== 32'd8) begin errors++; $display("FAIL to_stall_cycles: got %0d expected 8", bus.stall_cycles); end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL to_idle: got ready=%b busy=%b expected ready=1 busy=0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_walk1_gap();
    logic [8:0]    exp_w;
    logic [DW-1:0] exp_d[9];
    exp_w = 9'b0_0100_1001;
    exp_d = '{32'h1, 32'h2, 32'h2, 32'h2, 32'h4, 32'h4, 32'h4, 32'h8, 32'h8};
    send_cmd(16'd3, PAT_WALK1, 32'hDEAD_BEEF, 4'd2, 1'b0);
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL walk_err_cleared: got %b expected 0", bus.err_timeout); end
    run(9, 32'h0);
    for (int i = 0; i < 9; i++) begin
      checks++; if (log_winc[i] !== exp_w[i]) begin errors++; $display("FAIL walk_winc[%0d]: got %b expected %b", i, log_winc[i], exp_w[i]); end
      if (exp_w[i]) begin
        checks++; if (log_wdata[i] !== exp_d[i]) begin errors++; $display("FAIL walk_wdata[%0d]: got %h expected %h", i, log_wdata[i], exp_d[i]); end
      end
      checks++; if (log_done[i] !== (i == 7)) begin errors++; $display("FAIL walk_done[%0d]: got %b expected %b", i, log_done[i], (i == 7)); end
    end
  endtask

  task automatic test_lfsr_const();
    logic [DW-1:0] exp_l[3];
    exp_l = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002};
    send_cmd(16'd3, PAT_LFSR, 32'h0, 4'd0, 1'b0);
    run(4, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (log_winc[i] !== 1'b1 || log_wdata[i] !== exp_l[i]) begin
        errors++; $display("FAIL lfsr_word[%0d]: got winc=%b %h expected winc=1 %h", i, log_winc[i], log_wdata[i], exp_l[i]);
      end
    end
    checks++; if (log_done[3] !== 1'b1) begin errors++; $display("FAIL lfsr_done: got %b expected 1", log_done[3]); end
    send_cmd(16'd3, PAT_CONST, 32'hA5A5_0F0F, 4'd0, 1'b0);
    run(4, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (log_winc[i] !== 1'b1 || log_wdata[i] !== 32'hA5A5_0F0F) begin
        errors++; $display("FAIL const_word[%0d]: got winc=%b %h expected winc=1 a5a50f0f", i, log_winc[i], log_wdata[i]);
      end
    end
    checks++; if (log_winc[3] !== 1'b0) begin errors++; $display("FAIL const_end_winc: got %b expected 0", log_winc[3]); end
  endtask

  task automatic test_abort();
    send_cmd(16'd100, PAT_INCR, 32'h0, 4'd0, 1'b0);
    run(5, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (log_winc[i] !== 1'b1 || log_wdata[i] !== 32'(i)) begin
        errors++; $display("FAIL abort_pre_word[%0d]: got winc=%b %h expected winc=1 %h", i, log_winc[i], log_wdata[i], 32'(i));
      end
    end
    bus.abort = 1'b1;
    #1;
    checks++; if (bus.winc !== 1'b0) begin errors++; $display("FAIL abort_winc_same_cycle: got %b expected 0", bus.winc); end
    @(posedge wclk);
    #1;
    bus.abort = 1'b0;
    checks++; if (bus.done !== 1'b1)      begin errors++; $display("FAIL abort_done: got %b expected 1", bus.done); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.wr_count !== 16'd5) begin errors++; $display("FAIL abort_wr_count: got %0d expected 5", bus.wr_count); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", bus.cmd_ready); end
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL abort_idle_ignored: got done=%b expected 0", bus.done); end
    checks++; if (bus.wr_count !== 16'd5) begin errors++; $display("FAIL abort_count_hold: got %0d expected 5", bus.wr_count); end
  endtask

  task automatic test_zero_len();
    send_cmd(16'd0, PAT_INCR, 32'h77, 4'd0, 1'b0);
    #1;
    checks++; if (bus.done !== 1'b1)      begin errors++; $display("FAIL zlen_done: got %b expected 1", bus.done); end
    checks++; if (bus.busy !== 1'b0 || bus.winc !== 1'b0) begin
      errors++; $display("FAIL zlen_idle: got busy=%b winc=%b expected 0/0", bus.busy, bus.winc);
    end
    checks++; if (bus.wr_count !== 16'd0) begin errors++; $display("FAIL zlen_wr_cleared: got %0d expected 0", bus.wr_count); end
    cyc();
    checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL zlen_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_async_reset();
    send_cmd(16'd10, PAT_INCR, 32'h300, 4'd0, 1'b0);
    run(2, 32'h0);
    #2;
    wrst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.winc !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL arst_ctrl: got busy=%b winc=%b ready=%b expected 0/0/1", bus.busy, bus.winc, bus.cmd_ready);
    end
    checks++; if (bus.wr_count !== '0 || bus.wdata !== '0) begin
      errors++; $display("FAIL arst_data: got wr_count=%0d wdata=%h expected 0/0", bus.wr_count, bus.wdata);
    end
    #2;
    wrst = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_incr();
    test_stall();
    test_drop();
    test_timeout();
    test_walk1_gap();
    test_lfsr_const();
    test_abort();
    test_zero_len();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
